// File: rtl/cprv_pkg.sv
// Shared RV64I decode definitions: major opcodes and the immediate-format selector.
package cprv_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_fmt_e;

endpackage

// File: rtl/cprv_decode_stage_if.sv
// Fetch/RF/WB/EX-facing signal bundle of the decode stage; slave is the stage itself.
interface cprv_decode_stage_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int PC_WIDTH    = 64
);
  logic                   flush_i;
  logic                   valid_id_i;
  logic                   ready_id_o;
  logic [INSTR_WIDTH-1:0] instr_data_id_i;
  logic [PC_WIDTH-1:0]    pc_id_i;
  logic [4:0]             rs1_addr_rf_o;
  logic [4:0]             rs2_addr_rf_o;
  logic [DATA_WIDTH-1:0]  rs1_data_rf_i;
  logic [DATA_WIDTH-1:0]  rs2_data_rf_i;
  logic                   wb_w_en_i;
  logic [4:0]             wb_rd_addr_i;
  logic [DATA_WIDTH-1:0]  wb_rd_data_i;
  logic                   ex_load_i;
  logic [4:0]             ex_load_rd_i;
  logic                   valid_ex_o;
  logic                   ready_ex_i;
  logic [PC_WIDTH-1:0]    pc_ex_o;
  logic [DATA_WIDTH-1:0]  rs1_data_ex_o;
  logic [DATA_WIDTH-1:0]  rs2_data_ex_o;
  logic [DATA_WIDTH-1:0]  imm_data_ex_o;
  logic [4:0]             rd_addr_ex_o;
  logic                   rd_en_ex_o;
  logic [6:0]             opcode_ex_o;
  logic [2:0]             funct3_ex_o;
  logic [6:0]             funct7_ex_o;
  logic                   mem_r_en_ex_o;
  logic                   mem_w_en_ex_o;
  logic                   illegal_ex_o;

  modport slave (
    input  flush_i, valid_id_i, instr_data_id_i, pc_id_i,
    input  rs1_data_rf_i, rs2_data_rf_i,
    input  wb_w_en_i, wb_rd_addr_i, wb_rd_data_i,
    input  ex_load_i, ex_load_rd_i, ready_ex_i,
    output ready_id_o, rs1_addr_rf_o, rs2_addr_rf_o,
    output valid_ex_o, pc_ex_o, rs1_data_ex_o, rs2_data_ex_o, imm_data_ex_o,
    output rd_addr_ex_o, rd_en_ex_o, opcode_ex_o, funct3_ex_o, funct7_ex_o,
    output mem_r_en_ex_o, mem_w_en_ex_o, illegal_ex_o
  );

  modport master (
    output flush_i, valid_id_i, instr_data_id_i, pc_id_i,
    output rs1_data_rf_i, rs2_data_rf_i,
    output wb_w_en_i, wb_rd_addr_i, wb_rd_data_i,
    output ex_load_i, ex_load_rd_i, ready_ex_i,
    input  ready_id_o, rs1_addr_rf_o, rs2_addr_rf_o,
    input  valid_ex_o, pc_ex_o, rs1_data_ex_o, rs2_data_ex_o, imm_data_ex_o,
    input  rd_addr_ex_o, rd_en_ex_o, opcode_ex_o, funct3_ex_o, funct7_ex_o,
    input  mem_r_en_ex_o, mem_w_en_ex_o, illegal_ex_o
  );
endinterface

// File: rtl/cprv_imm_gen.sv
// Combinational immediate generator: picks the RV64I immediate layout and sign-extends it.
module cprv_imm_gen
  import cprv_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [31:0]           instr_i,
  input  imm_fmt_e              fmt_i,
  output logic [DATA_WIDTH-1:0] imm_o
);

  logic unused_opcode_s;
  assign unused_opcode_s = ^instr_i[6:0];

  // Immediate assembly per format; instr[31] is always the sign bit.
  always_comb begin
    imm_o = {DATA_WIDTH{1'b0}};
    case (fmt_i)
      IMM_I:    imm_o = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:20]};
      IMM_S:    imm_o = {{(DATA_WIDTH-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:    imm_o = {{(DATA_WIDTH-13){instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:    imm_o = {{(DATA_WIDTH-32){instr_i[31]}}, instr_i[31:12], 12'b0};
      IMM_J:    imm_o = {{(DATA_WIDTH-21){instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
      IMM_NONE: imm_o = {DATA_WIDTH{1'b0}};
      default:  imm_o = {DATA_WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/cprv_decode_stage.sv
// RV64I decode stage: decode tables, load-use hazard, WB bypass and a single
// valid/ready output register feeding EX.
module cprv_decode_stage
  import cprv_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int PC_WIDTH    = 64,
  parameter bit WB_BYPASS   = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  cprv_decode_stage_if.slave bus
);

  logic [INSTR_WIDTH-1:0] instr_s;
  logic [6:0]             opcode_s;
  logic [4:0]             rd_s;
  logic [4:0]             rs1_s;
  logic [4:0]             rs2_s;
  logic                   uses_rs1_s;
  logic                   uses_rs2_s;
  logic                   rd_en_s;
  logic                   mem_r_s;
  logic                   mem_w_s;
  logic                   illegal_s;
  imm_fmt_e               imm_fmt_s;
  logic [DATA_WIDTH-1:0]  imm_s;
  logic [DATA_WIDTH-1:0]  rs1_data_s;
  logic [DATA_WIDTH-1:0]  rs2_data_s;
  logic                   hazard_s;
  logic                   cke_s;
  logic                   ready_s;
  logic                   fire_s;

  logic                   valid_d,   valid_q;
  logic [PC_WIDTH-1:0]    pc_d,      pc_q;
  logic [DATA_WIDTH-1:0]  rs1_d,     rs1_q;
  logic [DATA_WIDTH-1:0]  rs2_d,     rs2_q;
  logic [DATA_WIDTH-1:0]  imm_d,     imm_q;
  logic [4:0]             rd_d,      rd_q;
  logic                   rd_en_d,   rd_en_q;
  logic [6:0]             opcode_d,  opcode_q;
  logic [2:0]             funct3_d,  funct3_q;
  logic [6:0]             funct7_d,  funct7_q;
  logic                   mem_r_d,   mem_r_q;
  logic                   mem_w_d,   mem_w_q;
  logic                   illegal_d, illegal_q;

  assign instr_s  = bus.instr_data_id_i;
  assign opcode_s = instr_s[6:0];
  assign rd_s     = instr_s[11:7];
  assign rs1_s    = instr_s[19:15];
  assign rs2_s    = instr_s[24:20];

  assign bus.rs1_addr_rf_o = rs1_s;
  assign bus.rs2_addr_rf_o = rs2_s;

  // Opcode decode table; anything unlisted is flagged illegal with no side effects.
  always_comb begin
    uses_rs1_s = 1'b1;
    uses_rs2_s = 1'b0;
    rd_en_s    = 1'b0;
    mem_r_s    = 1'b0;
    mem_w_s    = 1'b0;
    illegal_s  = 1'b0;
    imm_fmt_s  = IMM_NONE;
    case (opcode_s)
      OPC_OP, OPC_OP_32: begin
        uses_rs2_s = 1'b1;
        rd_en_s    = 1'b1;
      end
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: begin
        rd_en_s   = 1'b1;
        imm_fmt_s = IMM_I;
      end
      OPC_LOAD: begin
        rd_en_s   = 1'b1;
        mem_r_s   = 1'b1;
        imm_fmt_s = IMM_I;
      end
      OPC_STORE: begin
        uses_rs2_s = 1'b1;
        mem_w_s    = 1'b1;
        imm_fmt_s  = IMM_S;
      end
      OPC_BRANCH: begin
        uses_rs2_s = 1'b1;
        imm_fmt_s  = IMM_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        uses_rs1_s = 1'b0;
        rd_en_s    = 1'b1;
        imm_fmt_s  = IMM_U;
      end
      OPC_JAL: begin
        uses_rs1_s = 1'b0;
        rd_en_s    = 1'b1;
        imm_fmt_s  = IMM_J;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
    if (rd_s == 5'd0) begin
      rd_en_s = 1'b0;
    end else begin
      rd_en_s = rd_en_s;
    end
  end

  cprv_imm_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_imm_gen (
    .instr_i (instr_s[31:0]),
    .fmt_i   (imm_fmt_s),
    .imm_o   (imm_s)
  );

  // Operand read: x0 is hard zero, a same-cycle WB write wins over the RF array.
  always_comb begin
    rs1_data_s = bus.rs1_data_rf_i;
    rs2_data_s = bus.rs2_data_rf_i;
    if (rs1_s == 5'd0) begin
      rs1_data_s = {DATA_WIDTH{1'b0}};
    end else if (WB_BYPASS && bus.wb_w_en_i && (bus.wb_rd_addr_i == rs1_s)) begin
      rs1_data_s = bus.wb_rd_data_i;
    end else begin
      rs1_data_s = bus.rs1_data_rf_i;
    end
    if (rs2_s == 5'd0) begin
      rs2_data_s = {DATA_WIDTH{1'b0}};
    end else if (WB_BYPASS && bus.wb_w_en_i && (bus.wb_rd_addr_i == rs2_s)) begin
      rs2_data_s = bus.wb_rd_data_i;
    end else begin
      rs2_data_s = bus.rs2_data_rf_i;
    end
  end

  assign hazard_s = bus.valid_id_i & bus.ex_load_i & (bus.ex_load_rd_i != 5'd0) &
                    ((uses_rs1_s & (bus.ex_load_rd_i == rs1_s)) |
                     (uses_rs2_s & (bus.ex_load_rd_i == rs2_s)));
  assign cke_s    = ~valid_q | bus.ready_ex_i;
  assign ready_s  = cke_s & ~hazard_s & ~bus.flush_i;
  assign fire_s   = bus.valid_id_i & ready_s;

  assign bus.ready_id_o = ready_s;

  // Output register next state: flush beats everything, a stalled EX freezes all.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    rd_en_d   = rd_en_q;
    opcode_d  = opcode_q;
    funct3_d  = funct3_q;
    funct7_d  = funct7_q;
    mem_r_d   = mem_r_q;
    mem_w_d   = mem_w_q;
    illegal_d = illegal_q;
    if (bus.flush_i) begin
      valid_d = 1'b0;
    end else if (cke_s) begin
      valid_d = fire_s;
      if (fire_s) begin
        pc_d      = bus.pc_id_i;
        rs1_d     = rs1_data_s;
        rs2_d     = rs2_data_s;
        imm_d     = imm_s;
        rd_d      = rd_s;
        rd_en_d   = rd_en_s;
        opcode_d  = opcode_s;
        funct3_d  = instr_s[14:12];
        funct7_d  = instr_s[31:25];
        mem_r_d   = mem_r_s;
        mem_w_d   = mem_w_s;
        illegal_d = illegal_s;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Output register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= {PC_WIDTH{1'b0}};
      rs1_q     <= {DATA_WIDTH{1'b0}};
      rs2_q     <= {DATA_WIDTH{1'b0}};
      imm_q     <= {DATA_WIDTH{1'b0}};
      rd_q      <= 5'd0;
      rd_en_q   <= 1'b0;
      opcode_q  <= 7'd0;
      funct3_q  <= 3'd0;
      funct7_q  <= 7'd0;
      mem_r_q   <= 1'b0;
      mem_w_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      rd_q      <= rd_d;
      rd_en_q   <= rd_en_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
      funct7_q  <= funct7_d;
      mem_r_q   <= mem_r_d;
      mem_w_q   <= mem_w_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.valid_ex_o    = valid_q;
  assign bus.pc_ex_o       = pc_q;
  assign bus.rs1_data_ex_o = rs1_q;
  assign bus.rs2_data_ex_o = rs2_q;
  assign bus.imm_data_ex_o = imm_q;
  assign bus.rd_addr_ex_o  = rd_q;
  assign bus.rd_en_ex_o    = rd_en_q;
  assign bus.opcode_ex_o   = opcode_q;
  assign bus.funct3_ex_o   = funct3_q;
  assign bus.funct7_ex_o   = funct7_q;
  assign bus.mem_r_en_ex_o = mem_r_q;
  assign bus.mem_w_en_ex_o = mem_w_q;
  assign bus.illegal_ex_o  = illegal_q;

endmodule

// File: tb/tb_cprv_decode_stage.sv
// Directed-vector bench for cprv_decode_stage with hand-computed expectations.
module tb_cprv_decode_stage;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;

  cprv_decode_stage_if #(.INSTR_WIDTH(32), .DATA_WIDTH(64), .PC_WIDTH(64)) bus_if ();

  cprv_decode_stage #(
    .INSTR_WIDTH (32),
    .DATA_WIDTH  (64),
    .PC_WIDTH    (64),
    .WB_BYPASS   (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [63:0] pc);
    bus_if.valid_id_i      = 1'b1;
    bus_if.instr_data_id_i = instr;
    bus_if.pc_id_i         = pc;
    tick();
    bus_if.valid_id_i      = 1'b0;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n                  = 1'b0;
    bus_if.flush_i         = 1'b0;
    bus_if.valid_id_i      = 1'b0;
    bus_if.instr_data_id_i = 32'h0;
    bus_if.pc_id_i         = 64'h0;
    bus_if.rs1_data_rf_i   = 64'h0;
    bus_if.rs2_data_rf_i   = 64'h0;
    bus_if.wb_w_en_i       = 1'b0;
    bus_if.wb_rd_addr_i    = 5'd0;
    bus_if.wb_rd_data_i    = 64'h0;
    bus_if.ex_load_i       = 1'b0;
    bus_if.ex_load_rd_i    = 5'd0;
    bus_if.ready_ex_i      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_valid",   64'(bus_if.valid_ex_o),    64'h0);
    check_vec("rst_rd_en",   64'(bus_if.rd_en_ex_o),    64'h0);
    check_vec("rst_mem_w",   64'(bus_if.mem_w_en_ex_o), 64'h0);
    check_vec("rst_illegal", 64'(bus_if.illegal_ex_o),  64'h0);
    check_vec("rst_imm",     bus_if.imm_data_ex_o,      64'h0);
    rst_n = 1'b1;
    bus_if.ready_ex_i = 1'b1;
    tick();

    // addi x1,x0,-1
    bus_if.valid_id_i      = 1'b1;
    bus_if.instr_data_id_i = 32'hFFF00093;
    bus_if.pc_id_i         = 64'h100;
    #1;
    check_vec("addi_ready", 64'(bus_if.ready_id_o), 64'h1);
    tick();
    bus_if.valid_id_i = 1'b0;
    check_vec("addi_valid",  64'(bus_if.valid_ex_o),  64'h1);
    check_vec("addi_imm",    bus_if.imm_data_ex_o,    64'hFFFF_FFFF_FFFF_FFFF);
    check_vec("addi_rd",     64'(bus_if.rd_addr_ex_o), 64'h1);
    check_vec("addi_rd_en",  64'(bus_if.rd_en_ex_o),  64'h1);
    check_vec("addi_opcode", 64'(bus_if.opcode_ex_o), 64'h13);
    check_vec("addi_pc",     bus_if.pc_ex_o,          64'h100);

    // sd x2,8(x1)
    bus_if.rs1_data_rf_i   = 64'h1111;
    bus_if.rs2_data_rf_i   = 64'h2222;
    bus_if.instr_data_id_i = 32'h0020B423;
    #1;
    check_vec("sd_rs1_addr", 64'(bus_if.rs1_addr_rf_o), 64'h1);
    check_vec("sd_rs2_addr", 64'(bus_if.rs2_addr_rf_o), 64'h2);
    send(32'h0020B423, 64'h104);
    check_vec("sd_imm",    bus_if.imm_data_ex_o,         64'h8);
    check_vec("sd_mem_w",  64'(bus_if.mem_w_en_ex_o),    64'h1);
    check_vec("sd_mem_r",  64'(bus_if.mem_r_en_ex_o),    64'h0);
    check_vec("sd_rd_en",  64'(bus_if.rd_en_ex_o),       64'h0);
    check_vec("sd_funct3", 64'(bus_if.funct3_ex_o),      64'h3);
    check_vec("sd_rs1",    bus_if.rs1_data_ex_o,         64'h1111);
    check_vec("sd_rs2",    bus_if.rs2_data_ex_o,         64'h2222);

    send(32'hFE000EE3, 64'h108);
    check_vec("beq_imm",   bus_if.imm_data_ex_o,         64'hFFFF_FFFF_FFFF_FFFC);
    check_vec("beq_rd_en", 64'(bus_if.rd_en_ex_o),       64'h0);

    send(32'h123452B7, 64'h10C);
    check_vec("lui_imm",   bus_if.imm_data_ex_o,         64'h12345000);
    check_vec("lui_rd",    64'(bus_if.rd_addr_ex_o),     64'h5);
    check_vec("lui_rd_en", 64'(bus_if.rd_en_ex_o),       64'h1);

    send(32'h0080B183, 64'h110);
    check_vec("ld_mem_r",  64'(bus_if.mem_r_en_ex_o),    64'h1);
    check_vec("ld_imm",    bus_if.imm_data_ex_o,         64'h8);
    check_vec("ld_rd",     64'(bus_if.rd_addr_ex_o),     64'h3);

    tick();
    check_vec("idle_valid", 64'(bus_if.valid_ex_o), 64'h0);

    // load-use hazard on add x3,x1,x2
    bus_if.ex_load_i       = 1'b1;
    bus_if.ex_load_rd_i    = 5'd1;
    bus_if.valid_id_i      = 1'b1;
    bus_if.instr_data_id_i = 32'h002081B3;
    bus_if.pc_id_i         = 64'h200;
    #1;
    check_vec("haz_ready", 64'(bus_if.ready_id_o), 64'h0);
    tick();
    check_vec("haz_bubble", 64'(bus_if.valid_ex_o), 64'h0);
    check_vec("haz_ready2", 64'(bus_if.ready_id_o), 64'h0);
    bus_if.ex_load_i = 1'b0;
    #1;
    check_vec("haz_release", 64'(bus_if.ready_id_o), 64'h1);
    tick();
    bus_if.valid_id_i = 1'b0;
    check_vec("add_valid",  64'(bus_if.valid_ex_o),   64'h1);
    check_vec("add_rd",     64'(bus_if.rd_addr_ex_o), 64'h3);
    check_vec("add_opcode", 64'(bus_if.opcode_ex_o),  64'h33);

    // load to x0 never hazards
    bus_if.ex_load_i       = 1'b1;
    bus_if.ex_load_rd_i    = 5'd0;
    bus_if.valid_id_i      = 1'b1;
    bus_if.instr_data_id_i = 32'hFFF00093;
    #1;
    check_vec("haz_x0_ready", 64'(bus_if.ready_id_o), 64'h1);
    bus_if.valid_id_i = 1'b0;
    bus_if.ex_load_i  = 1'b0;

    // WB bypass on addi x2,x1,1
    bus_if.rs1_data_rf_i = 64'h10;
    bus_if.wb_w_en_i     = 1'b1;
    bus_if.wb_rd_addr_i  = 5'd1;
    bus_if.wb_rd_data_i  = 64'h55;
    send(32'h00108113, 64'h300);
    check_vec("byp_rs1", bus_if.rs1_data_ex_o, 64'h55);
    bus_if.wb_rd_addr_i = 5'd0;
    send(32'h00108113, 64'h304);
    check_vec("byp_off_rs1", bus_if.rs1_data_ex_o, 64'h10);
    send(32'hFFF00093, 64'h308);
    check_vec("x0_rs1", bus_if.rs1_data_ex_o, 64'h0);
    bus_if.wb_w_en_i = 1'b0;

    // backpressure then flush
    send(32'h00108113, 64'h400);
    bus_if.ready_ex_i      = 1'b0;
    bus_if.valid_id_i      = 1'b1;
    bus_if.instr_data_id_i = 32'h123452B7;
    bus_if.pc_id_i         = 64'h404;
    #1;
    check_vec("stall_ready", 64'(bus_if.ready_id_o), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_vec("stall_valid", 64'(bus_if.valid_ex_o),   64'h1);
      check_vec("stall_imm",   bus_if.imm_data_ex_o,     64'h1);
      check_vec("stall_rd",    64'(bus_if.rd_addr_ex_o), 64'h2);
      check_vec("stall_pc",    bus_if.pc_ex_o,           64'h400);
    end
    bus_if.flush_i = 1'b1;
    tick();
    check_vec("flush_valid", 64'(bus_if.valid_ex_o), 64'h0);
    bus_if.flush_i    = 1'b0;
    bus_if.valid_id_i = 1'b0;
    bus_if.ready_ex_i = 1'b1;

    // illegal opcode 0x7F, then async reset while stalled
    send(32'h0000017F, 64'h500);
    check_vec("ill_valid",   64'(bus_if.valid_ex_o),    64'h1);
    check_vec("ill_flag",    64'(bus_if.illegal_ex_o),  64'h1);
    check_vec("ill_rd_en",   64'(bus_if.rd_en_ex_o),    64'h0);
    check_vec("ill_mem_r",   64'(bus_if.mem_r_en_ex_o), 64'h0);
    check_vec("ill_mem_w",   64'(bus_if.mem_w_en_ex_o), 64'h0);
    check_vec("ill_imm",     bus_if.imm_data_ex_o,      64'h0);
    bus_if.ready_ex_i = 1'b0;
    tick();
    check_vec("ill_hold", 64'(bus_if.valid_ex_o), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("arst_valid",   64'(bus_if.valid_ex_o),   64'h0);
    check_vec("arst_illegal", 64'(bus_if.illegal_ex_o), 64'h0);
    tick();
    rst_n = 1'b1;
    bus_if.ready_ex_i = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
